// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and requester ids for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY_INST = 2'd1,
        ST_BUSY_DATA = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_e;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    // Element width code driven on instruction fetches (full scalar word).
    localparam logic [2:0] DTYPE_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational winner select between IF and MEM requesters
// Optional: MEM_ARB_ROUND_ROBIN_EN enables alternation when both requests are pending.
module mem_arb_grant
    import mem_port_arbiter_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = inst_req | data_req;
        grant_id    = REQ_INST;
        if (inst_req && data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_id = (last_grant == REQ_DATA) ? REQ_INST : REQ_DATA;
`else
            grant_id = REQ_DATA;
`endif
        end else if (data_req) begin
            grant_id = REQ_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - one-outstanding arbiter sharing the main-memory port between IF and MEM
// Optional: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_in,
    input  logic                          inst_req,
    input  logic [ADDR_WIDTH-1:0]         inst_addr,
    output logic                          inst_done,
    output logic [LEN-1:0]                inst_rdata,
    input  logic                          data_req,
    input  logic                          data_we,
    input  logic                          data_is_vector,
    input  logic [ADDR_WIDTH-1:0]         data_addr,
    input  logic [2:0]                    data_type,
    input  logic [ENTRY_INDEX_SIZE:0]     data_vlen,
    input  logic [LEN-1:0]                data_wdata_scalar,
    input  logic [LEN*VECTOR_SIZE-1:0]    data_wdata_vector,
    output logic                          data_done,
    output logic [LEN-1:0]                data_rdata_scalar,
    output logic [LEN*VECTOR_SIZE-1:0]    data_rdata_vector,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic                          mem_is_vector,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [2:0]                    mem_data_type,
    output logic [ENTRY_INDEX_SIZE:0]     mem_vlen,
    output logic [LEN-1:0]                mem_wdata_scalar,
    output logic [LEN*VECTOR_SIZE-1:0]    mem_wdata_vector,
    input  logic                          mem_done,
    input  logic [LEN-1:0]                mem_rdata_scalar,
    input  logic [LEN*VECTOR_SIZE-1:0]    mem_rdata_vector
);

    arb_state_e                   state_q, state_d;
    logic                         inst_done_q, inst_done_d;
    logic                         data_done_q, data_done_d;
    logic [LEN-1:0]               inst_rdata_q, inst_rdata_d;
    logic [LEN-1:0]               data_rdata_scalar_q, data_rdata_scalar_d;
    logic [LEN*VECTOR_SIZE-1:0]   data_rdata_vector_q, data_rdata_vector_d;
    logic                         mem_req_q, mem_req_d;
    logic                         mem_we_q, mem_we_d;
    logic                         mem_is_vector_q, mem_is_vector_d;
    logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
    logic [2:0]                   mem_data_type_q, mem_data_type_d;
    logic [ENTRY_INDEX_SIZE:0]    mem_vlen_q, mem_vlen_d;
    logic [LEN-1:0]               mem_wdata_scalar_q, mem_wdata_scalar_d;
    logic [LEN*VECTOR_SIZE-1:0]   mem_wdata_vector_q, mem_wdata_vector_d;
    logic                         zero_len_q, zero_len_d;
    logic                         grant_valid;
    logic                         grant_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                         last_grant_q, last_grant_d;
`endif

    mem_arb_grant u_grant (
        .inst_req    (inst_req),
        .data_req    (data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_q),
`endif
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d             = state_q;
        inst_done_d         = 1'b0;
        data_done_d         = 1'b0;
        inst_rdata_d        = inst_rdata_q;
        data_rdata_scalar_d = data_rdata_scalar_q;
        data_rdata_vector_d = data_rdata_vector_q;
        mem_req_d           = 1'b0;
        mem_we_d            = mem_we_q;
        mem_is_vector_d     = mem_is_vector_q;
        mem_addr_d          = mem_addr_q;
        mem_data_type_d     = mem_data_type_q;
        mem_vlen_d          = mem_vlen_q;
        mem_wdata_scalar_d  = mem_wdata_scalar_q;
        mem_wdata_vector_d  = mem_wdata_vector_q;
        zero_len_d          = zero_len_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d        = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_id;
`endif
                    if (grant_id == REQ_DATA) begin
                        state_d = ST_BUSY_DATA;
                        // A zero-length vector spends its busy cycle without touching memory.
                        if (data_is_vector && (data_vlen == '0)) begin
                            zero_len_d = 1'b1;
                        end else begin
                            zero_len_d         = 1'b0;
                            mem_req_d          = 1'b1;
                            mem_we_d           = data_we;
                            mem_is_vector_d    = data_is_vector;
                            mem_addr_d         = data_addr;
                            mem_data_type_d    = data_type;
                            mem_vlen_d         = data_vlen;
                            mem_wdata_scalar_d = data_wdata_scalar;
                            mem_wdata_vector_d = data_wdata_vector;
                        end
                    end else begin
                        state_d            = ST_BUSY_INST;
                        zero_len_d         = 1'b0;
                        mem_req_d          = 1'b1;
                        mem_we_d           = 1'b0;
                        mem_is_vector_d    = 1'b0;
                        mem_addr_d         = inst_addr;
                        mem_data_type_d    = DTYPE_WORD;
                        mem_vlen_d         = '0;
                        mem_wdata_scalar_d = '0;
                        mem_wdata_vector_d = '0;
                    end
                end
            end
            ST_BUSY_INST: begin
                if (mem_done) begin
                    inst_rdata_d = mem_rdata_scalar;
                    inst_done_d  = 1'b1;
                    state_d      = ST_RESP;
                end
            end
            ST_BUSY_DATA: begin
                if (zero_len_q) begin
                    zero_len_d  = 1'b0;
                    data_done_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (mem_done) begin
                    if (!mem_we_q) begin
                        if (mem_is_vector_q) begin
                            data_rdata_vector_d = mem_rdata_vector;
                        end else begin
                            data_rdata_scalar_d = mem_rdata_scalar;
                        end
                    end
                    data_done_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            inst_done_q         <= 1'b0;
            data_done_q         <= 1'b0;
            inst_rdata_q        <= '0;
            data_rdata_scalar_q <= '0;
            data_rdata_vector_q <= '0;
            mem_req_q           <= 1'b0;
            mem_we_q            <= 1'b0;
            mem_is_vector_q     <= 1'b0;
            mem_addr_q          <= '0;
            mem_data_type_q     <= '0;
            mem_vlen_q          <= '0;
            mem_wdata_scalar_q  <= '0;
            mem_wdata_vector_q  <= '0;
            zero_len_q          <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q        <= REQ_INST;
`endif
        end else if (rdy_in) begin
            state_q             <= state_d;
            inst_done_q         <= inst_done_d;
            data_done_q         <= data_done_d;
            inst_rdata_q        <= inst_rdata_d;
            data_rdata_scalar_q <= data_rdata_scalar_d;
            data_rdata_vector_q <= data_rdata_vector_d;
            mem_req_q           <= mem_req_d;
            mem_we_q            <= mem_we_d;
            mem_is_vector_q     <= mem_is_vector_d;
            mem_addr_q          <= mem_addr_d;
            mem_data_type_q     <= mem_data_type_d;
            mem_vlen_q          <= mem_vlen_d;
            mem_wdata_scalar_q  <= mem_wdata_scalar_d;
            mem_wdata_vector_q  <= mem_wdata_vector_d;
            zero_len_q          <= zero_len_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q        <= last_grant_d;
`endif
        end
    end

    assign inst_done         = inst_done_q;
    assign inst_rdata        = inst_rdata_q;
    assign data_done         = data_done_q;
    assign data_rdata_scalar = data_rdata_scalar_q;
    assign data_rdata_vector = data_rdata_vector_q;
    assign mem_req           = mem_req_q;
    assign mem_we            = mem_we_q;
    assign mem_is_vector     = mem_is_vector_q;
    assign mem_addr          = mem_addr_q;
    assign mem_data_type     = mem_data_type_q;
    assign mem_vlen          = mem_vlen_q;
    assign mem_wdata_scalar  = mem_wdata_scalar_q;
    assign mem_wdata_vector  = mem_wdata_vector_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench with a transaction-level arbiter model
// Optional: MEM_ARB_ROUND_ROBIN_EN must match the RTL build.
module tb_mem_port_arbiter;

    localparam int AW = 17;
    localparam int L  = 32;
    localparam int VW = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic           rdy_in;
    logic           inst_req;
    logic [AW-1:0]  inst_addr;
    logic           inst_done;
    logic [L-1:0]   inst_rdata;
    logic           data_req;
    logic           data_we;
    logic           data_is_vector;
    logic [AW-1:0]  data_addr;
    logic [2:0]     data_type;
    logic [3:0]     data_vlen;
    logic [L-1:0]   data_wdata_scalar;
    logic [VW-1:0]  data_wdata_vector;
    logic           data_done;
    logic [L-1:0]   data_rdata_scalar;
    logic [VW-1:0]  data_rdata_vector;
    logic           mem_req;
    logic           mem_we;
    logic           mem_is_vector;
    logic [AW-1:0]  mem_addr;
    logic [2:0]     mem_data_type;
    logic [3:0]     mem_vlen;
    logic [L-1:0]   mem_wdata_scalar;
    logic [VW-1:0]  mem_wdata_vector;
    logic           mem_done;
    logic [L-1:0]   mem_rdata_scalar;
    logic [VW-1:0]  mem_rdata_vector;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: expected read-data registers and who was granted last (0=inst, 1=data).
    logic [L-1:0]   exp_inst;
    logic [L-1:0]   exp_ds;
    logic [VW-1:0]  exp_dv;
    bit             mdl_last;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .rdy_in            (rdy_in),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_done         (inst_done),
        .inst_rdata        (inst_rdata),
        .data_req          (data_req),
        .data_we           (data_we),
        .data_is_vector    (data_is_vector),
        .data_addr         (data_addr),
        .data_type         (data_type),
        .data_vlen         (data_vlen),
        .data_wdata_scalar (data_wdata_scalar),
        .data_wdata_vector (data_wdata_vector),
        .data_done         (data_done),
        .data_rdata_scalar (data_rdata_scalar),
        .data_rdata_vector (data_rdata_vector),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_is_vector     (mem_is_vector),
        .mem_addr          (mem_addr),
        .mem_data_type     (mem_data_type),
        .mem_vlen          (mem_vlen),
        .mem_wdata_scalar  (mem_wdata_scalar),
        .mem_wdata_vector  (mem_wdata_vector),
        .mem_done          (mem_done),
        .mem_rdata_scalar  (mem_rdata_scalar),
        .mem_rdata_vector  (mem_rdata_vector)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit pick(input bit ip, input bit dp);
        if (ip && !dp) return 1'b0;
        if (dp && !ip) return 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !mdl_last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_rdata();
        chk("inst_rdata", inst_rdata, exp_inst);
        chk("data_rdata_scalar", data_rdata_scalar, exp_ds);
        chk("data_rdata_vector", data_rdata_vector, exp_dv);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dones"}, {inst_done, data_done, mem_req, mem_we, mem_is_vector}, 0);
        chk({tag, "_mem_fields"}, {mem_addr, mem_data_type, mem_vlen, mem_wdata_scalar}, 0);
        chk({tag, "_mem_wdata_vector"}, mem_wdata_vector, 0);
        chk({tag, "_rdata_scalars"}, {inst_rdata, data_rdata_scalar}, 0);
        chk({tag, "_data_rdata_vector"}, data_rdata_vector, 0);
    endtask

    task automatic model_reset();
        exp_inst = '0;
        exp_ds   = '0;
        exp_dv   = '0;
        mdl_last = 1'b0;
    endtask

    // Entered in an IDLE cycle with requests driven; serves exactly one grant and
    // returns in the following IDLE cycle with the winner's request dropped.
    task automatic serve(input int dly, input logic [L-1:0] rs, input logic [VW-1:0] rv);
        bit who;
        bit zl;
        logic [AW-1:0] exp_addr;
        who      = pick(inst_req, data_req);
        zl       = who && data_is_vector && (data_vlen == 4'd0);
        mdl_last = who;
        exp_addr = who ? data_addr : inst_addr;
        step();
        if (zl) begin
            chk("zl_no_mem_req", mem_req, 0);
            chk("zl_no_early_done", data_done, 0);
            step();
            chk("zl_data_done", {inst_done, data_done}, 2'b01);
            chk("zl_mem_req", mem_req, 0);
            check_rdata();
        end else begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, exp_addr);
            if (who) begin
                chk("mem_we", mem_we, data_we);
                chk("mem_is_vector", mem_is_vector, data_is_vector);
                chk("mem_data_type", mem_data_type, data_type);
                chk("mem_vlen", mem_vlen, data_vlen);
                chk("mem_wdata_scalar", mem_wdata_scalar, data_wdata_scalar);
                chk("mem_wdata_vector", mem_wdata_vector, data_wdata_vector);
            end else begin
                chk("mem_we_fetch", {mem_we, mem_is_vector}, 0);
            end
            for (int i = 0; i < dly; i++) begin
                step();
                chk("mem_req_pulse", mem_req, 0);
                chk("no_early_done", {inst_done, data_done}, 0);
                chk("mem_addr_hold", mem_addr, exp_addr);
            end
            mem_rdata_scalar = rs;
            mem_rdata_vector = rv;
            mem_done         = 1'b1;
            step();
            mem_done = 1'b0;
            if (!who) exp_inst = rs;
            else if (!data_we) begin
                if (data_is_vector) exp_dv = rv;
                else exp_ds = rs;
            end
            chk("done_winner", {inst_done, data_done}, who ? 2'b01 : 2'b10);
            check_rdata();
        end
        if (who) data_req = 1'b0;
        else inst_req = 1'b0;
        step();
        chk("done_cleared", {inst_done, data_done, mem_req}, 0);
    endtask

    task automatic rand_fields();
        inst_addr         = AW'($urandom);
        data_we           = 1'($urandom);
        data_is_vector    = 1'($urandom);
        data_addr         = AW'($urandom);
        data_type         = 3'($urandom);
        data_vlen         = 4'($urandom_range(0, 8));
        data_wdata_scalar = $urandom;
        data_wdata_vector = rand_vec();
    endtask

    initial begin
        bit who;
        rst = 1'b1; rdy_in = 1'b1;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_we = 0; data_is_vector = 0; data_addr = 0;
        data_type = 0; data_vlen = 0; data_wdata_scalar = 0; data_wdata_vector = 0;
        mem_done = 0; mem_rdata_scalar = 0; mem_rdata_vector = 0;
        model_reset();
        step(); step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Single fetch, memory answers 3 cycles after mem_req.
        inst_addr = 17'h00010;
        inst_req  = 1'b1;
        serve(3, 32'h00500093, rand_vec());
        chk("fetch_rdata_value", inst_rdata, 32'h00500093);

        // Vector write of 8 elements.
        data_we = 1'b1; data_is_vector = 1'b1; data_vlen = 4'd8; data_type = 3'b010;
        data_addr = 17'h01230; data_wdata_scalar = $urandom; data_wdata_vector = rand_vec();
        data_req = 1'b1;
        serve(1, $urandom, rand_vec());

        // Zero-length vector read.
        data_we = 1'b0; data_vlen = 4'd0;
        data_req = 1'b1;
        serve(2, $urandom, rand_vec());

        // Contention: both requests raised in the same cycle.
        rand_fields();
        data_is_vector = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        while (inst_req || data_req) serve($urandom_range(1, 3), $urandom, rand_vec());

        // Reset while the data access is outstanding, then a late mem_done.
        data_we = 1'b0; data_is_vector = 1'b0; data_addr = 17'h00444;
        data_req = 1'b1;
        step();
        chk("rst_mem_req", mem_req, 1);
        rst = 1'b1; data_req = 1'b0;
        step();
        check_all_zero("midrst");
        rst = 1'b0;
        model_reset();
        mem_rdata_scalar = $urandom; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        chk("late_done_ignored", {inst_done, data_done, mem_req}, 0);
        chk("late_done_rdata", data_rdata_scalar, 0);
        step();

        // Global stall during the response cycle with the other requester waiting.
        rand_fields();
        data_is_vector = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        who = pick(1'b1, 1'b1);
        mdl_last = who;
        step();
        chk("stall_mem_req", mem_req, 1);
        mem_rdata_scalar = $urandom; mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        if (!who) exp_inst = mem_rdata_scalar;
        else if (!data_we) exp_ds = mem_rdata_scalar;
        chk("stall_done_first", {inst_done, data_done}, who ? 2'b01 : 2'b10);
        if (who) data_req = 1'b0;
        else inst_req = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_done_held", {inst_done, data_done}, who ? 2'b01 : 2'b10);
            chk("stall_no_grant", mem_req, 0);
        end
        rdy_in = 1'b1;
        step();
        chk("stall_released", {inst_done, data_done, mem_req}, 0);
        check_rdata();
        serve(1, $urandom, rand_vec());

        // Randomized traffic: single and contending requests with varied memory latency.
        for (int it = 0; it < 40; it++) begin
            int mode;
            rand_fields();
            mode = $urandom_range(0, 2);
            inst_req = (mode != 1);
            data_req = (mode != 0);
            while (inst_req || data_req) serve($urandom_range(1, 3), $urandom, rand_vec());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the core's single main-memory port between two requesters: the IF stage (scalar instruction reads) and the MEM stage (scalar/vector data reads and writes).
- Sequences each access as a one-outstanding transaction through a four-state FSM, registers the read data, and returns a one-cycle done pulse to the winning requester.
- Sits between the pipeline core and main memory; it replaces direct drive of the memory address, enable and data-type lines by the core.

## Interface
Parameters:
- ADDR_WIDTH, 17, memory address width
- LEN, 32, scalar word width
- VECTOR_SIZE, 8, scalar words per vector register
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE); vector length field is ENTRY_INDEX_SIZE+1 bits

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset; one clock, synchronous reset, active-high
- rdy_in  in  1  global ready; low freezes all state and outputs
- inst_req  in  1  IF read request, held until inst_done
- inst_addr  in  ADDR_WIDTH  fetch address
- inst_done  out  1  one-cycle pulse; inst_rdata valid
- inst_rdata  out  LEN  fetched instruction
- data_req  in  1  MEM request, held until data_done
- data_we  in  1  1=write, 0=read
- data_is_vector  in  1  vector access
- data_addr  in  ADDR_WIDTH  data address
- data_type  in  3  element width code, passed through
- data_vlen  in  ENTRY_INDEX_SIZE+1  vector element count
- data_wdata_scalar  in  LEN / data_wdata_vector  in  LEN*VECTOR_SIZE  write data
- data_done  out  1  one-cycle pulse
- data_rdata_scalar  out  LEN / data_rdata_vector  out  LEN*VECTOR_SIZE  read data
- mem_req  out  1  one-cycle start pulse to memory
- mem_we, mem_is_vector  out  1 / mem_addr  out  ADDR_WIDTH / mem_data_type  out  3 / mem_vlen  out  ENTRY_INDEX_SIZE+1 / mem_wdata_scalar, mem_wdata_vector  out  LEN, LEN*VECTOR_SIZE  registered request fields
- mem_done  in  1  memory completion pulse
- mem_rdata_scalar  in  LEN / mem_rdata_vector  in  LEN*VECTOR_SIZE  memory read data, valid with mem_done

## Operation
- States: IDLE, BUSY_INST, BUSY_DATA, RESP.
- IDLE, arbitration:
  - data_req wins over inst_req (round-robin variant below).
  - On grant: latch the request fields into the mem_* registers, assert mem_req for exactly one cycle, and move to BUSY_x.
- Zero-length vector (data_is_vector=1, data_vlen=0): no mem_req is issued; go directly to RESP with data_done; read data outputs unchanged.
- BUSY_x:
  - Wait for mem_done, with no timeout.
  - On mem_done, capture the read data into the x_rdata registers; write accesses leave the rdata registers unchanged.
  - Pulse x_done and move to RESP.
- RESP: one cycle with no arbitration, then IDLE. This guarantees the requester has dropped its req before the next sample.
- mem_done in IDLE or RESP is ignored.
- mem_* fields are held stable from grant until leaving BUSY_x.
- Addresses are used as-is (ADDR_WIDTH bits); no alignment checks.

## Timing
- Reset values:
  - Outputs: all 0 (inst_done, data_done, mem_req, mem_we, mem_is_vector, mem_addr, mem_data_type, mem_vlen, all wdata/rdata).
  - State: IDLE; last_grant=inst.
- Latency:
  - Request sampled in IDLE at cycle 0; mem_req high in cycle 1.
  - mem_done at cycle k (k≥2); x_done and x_rdata valid in cycle k+1 (RESP).
  - Next grant possible at cycle k+2.
- Minimum turnaround is 4 cycles for a memory returning mem_done one cycle after mem_req.
- rdy_in=0: FSM, registers and outputs hold. The done pulse is extended for as long as rdy_in stays low. mem_done arriving while rdy_in=0 is lost; memory must not assert mem_done while rdy_in=0.
- Reset mid-transaction:
  - Abandon the transaction; go to IDLE next cycle with no done pulse.
  - A late mem_done after reset is ignored.
- Simultaneous inst_req and data_req in IDLE: one grant per cycle; the loser waits without loss.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: when both requests are pending in IDLE, grant the requester not granted last (last_grant register, updated on every grant).
  - Undefined: fixed priority, data over inst; last_grant is not implemented.

## Structure
- Shared package/defines:
  - State encodings: IDLE=2'd0, BUSY_INST=2'd1, BUSY_DATA=2'd2, RESP=2'd3.
  - Requester ID constants REQ_INST, REQ_DATA.
- Sub-module: one, mem_arb_grant. Combinational winner select from both reqs and last_grant, including the round-robin logic; the FSM stays in the top module.

## Test plan
- Single fetch: inst_req, inst_addr=0x00010, memory returns 0x00500093 with mem_done 3 cycles after mem_req → mem_addr=0x00010, mem_we=0, inst_done one cycle after mem_done, inst_rdata=0x00500093.
- Contention: both reqs in the same cycle, fixed priority → data granted first, inst granted at cycle k+2. With MEM_ARB_ROUND_ROBIN_EN and last_grant=data → inst first.
- Vector write: data_we=1, data_is_vector=1, data_vlen=8, data_type=3'b010 → mem_vlen=8, mem_wdata_vector matches input, data_done pulse, data_rdata_vector unchanged.
- Zero-length vector: data_vlen=0 → mem_req never asserted; data_done exactly 2 cycles after the request is sampled.
- Reset during BUSY_DATA, then mem_done the next cycle → no data_done, state IDLE, all outputs 0.
- rdy_in low for 3 cycles during RESP → data_done stays high 4 cycles total; no new grant.
